// File: rtl/cdb_arbiter.sv
// Common-data-bus writeback arbiter: per-FU one-entry holding registers, oldest-tag-first grant.
// Latency 2 cycles handshake->cdb_valid; fu_ready drops while an entry is held and not granted.
module cdb_arbiter #(
  parameter int NUM_FU        = 4,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int ORDER_WIDTH   = 64,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [NUM_FU-1:0]                 fu_valid,
  output logic [NUM_FU-1:0]                 fu_ready,
  input  logic [NUM_FU*ROB_IDX_WIDTH-1:0]   fu_rob_idx,
  input  logic [NUM_FU*5-1:0]               fu_rd_addr,
  input  logic [NUM_FU*DATA_WIDTH-1:0]      fu_data,
  input  logic [NUM_FU*ORDER_WIDTH-1:0]     fu_order,
  output logic                              cdb_valid,
  output logic [ROB_IDX_WIDTH-1:0]          cdb_rob_idx,
  output logic [4:0]                        cdb_rd_addr,
  output logic [DATA_WIDTH-1:0]             cdb_data,
  output logic [$clog2(NUM_FU)-1:0]         cdb_fu_id,
  output logic [NUM_FU*16-1:0]              grant_cnt
);

  localparam int FU_ID_W = $clog2(NUM_FU);

  typedef struct packed {
    logic [ORDER_WIDTH-1:0]   order;
    logic [ROB_IDX_WIDTH-1:0] rob_idx;
    logic [4:0]               rd_addr;
    logic [DATA_WIDTH-1:0]    data;
  } entry_t;

  entry_t               fu_in [NUM_FU];
  entry_t               hold  [NUM_FU];
  logic [NUM_FU-1:0]    hold_valid;
  logic [NUM_FU-1:0]    grant;
  logic [NUM_FU-1:0]    xfer;
  logic                 win_found;
  logic [FU_ID_W-1:0]   win_idx;
  logic [ORDER_WIDTH-1:0] win_order;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_in[i].order   = fu_order[i*ORDER_WIDTH +: ORDER_WIDTH];
      fu_in[i].rob_idx = fu_rob_idx[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
      fu_in[i].rd_addr = fu_rd_addr[i*5 +: 5];
      fu_in[i].data    = fu_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Ascending scan with strict '<' leaves ties with the lowest FU index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_order = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (hold_valid[i] && (!win_found || hold[i].order < win_order)) begin
        win_found = 1'b1;
        win_idx   = FU_ID_W'(i);
        win_order = hold[i].order;
      end
    end
    grant = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      grant[i] = win_found && (win_idx == FU_ID_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = !rst && !flush && (!hold_valid[i] || grant[i]);
    end
    xfer = fu_valid & fu_ready;
  end

  // Payload needs no reset: it is only observed while hold_valid is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (xfer[i]) hold[i] <= fu_in[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hold_valid  <= '0;
      cdb_valid   <= 1'b0;
      cdb_rob_idx <= '0;
      cdb_rd_addr <= '0;
      cdb_data    <= '0;
      cdb_fu_id   <= '0;
      if (rst) grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (xfer[i])       hold_valid[i] <= 1'b1;
        else if (grant[i]) hold_valid[i] <= 1'b0;
      end
      cdb_valid <= win_found;
      if (win_found) begin
        cdb_rob_idx <= hold[win_idx].rob_idx;
        cdb_rd_addr <= hold[win_idx].rd_addr;
        cdb_data    <= hold[win_idx].data;
        cdb_fu_id   <= win_idx;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (grant[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a set-of-held-results reference model.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int RW = 5;
  localparam int OW = 64;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst, flush;
  logic [N-1:0]    fu_valid, fu_ready;
  logic [N*RW-1:0] fu_rob_idx;
  logic [N*5-1:0]  fu_rd_addr;
  logic [N*DW-1:0] fu_data;
  logic [N*OW-1:0] fu_order;
  logic            cdb_valid;
  logic [RW-1:0]   cdb_rob_idx;
  logic [4:0]      cdb_rd_addr;
  logic [DW-1:0]   cdb_data;
  logic [1:0]      cdb_fu_id;
  logic [N*16-1:0] grant_cnt;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_rob_idx(fu_rob_idx), .fu_rd_addr(fu_rd_addr),
    .fu_data(fu_data), .fu_order(fu_order),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_rd_addr(cdb_rd_addr),
    .cdb_data(cdb_data), .cdb_fu_id(cdb_fu_id), .grant_cnt(grant_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: the set of results waiting, the last broadcast, and per-FU grant totals.
  bit            m_hv   [N];
  logic [RW-1:0] m_rob  [N];
  logic [4:0]    m_rd   [N];
  logic [DW-1:0] m_data [N];
  logic [OW-1:0] m_ord  [N];
  logic          m_cv    = 1'b0;
  logic [RW-1:0] m_crob  = '0;
  logic [4:0]    m_crd   = '0;
  logic [DW-1:0] m_cdata = '0;
  logic [1:0]    m_cid   = '0;
  int            m_cnt  [N];
  logic [N-1:0]  exp_rdy;

  // Oldest waiting result: smallest tag, then lowest FU number among equals.
  function automatic int oldest();
    logic [OW-1:0] mn;
    bit any;
    any = 0;
    mn  = '0;
    for (int i = 0; i < N; i++)
      if (m_hv[i] && (!any || m_ord[i] < mn)) begin mn = m_ord[i]; any = 1; end
    if (!any) return -1;
    for (int i = 0; i < N; i++)
      if (m_hv[i] && m_ord[i] == mn) return i;
    return -1;
  endfunction

  task automatic cycle();
    int w;
    logic [63:0] ecnt;
    w = oldest();
    for (int i = 0; i < N; i++) exp_rdy[i] = !rst && !flush && (!m_hv[i] || w == i);
    @(negedge clk);
    check("fu_ready", 64'(fu_ready), 64'(exp_rdy));
    @(posedge clk);
    if (rst || flush) begin
      for (int i = 0; i < N; i++) m_hv[i] = 0;
      m_cv = 0; m_crob = '0; m_crd = '0; m_cdata = '0; m_cid = '0;
      if (rst) for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      m_cv = (w >= 0);
      if (w >= 0) begin
        m_crob = m_rob[w]; m_crd = m_rd[w]; m_cdata = m_data[w]; m_cid = w[1:0];
        if (m_cnt[w] < 65535) m_cnt[w]++;
        m_hv[w] = 0;
      end
      for (int i = 0; i < N; i++)
        if (fu_valid[i] && exp_rdy[i]) begin
          m_hv[i]   = 1;
          m_rob[i]  = fu_rob_idx[i*RW +: RW];
          m_rd[i]   = fu_rd_addr[i*5 +: 5];
          m_data[i] = fu_data[i*DW +: DW];
          m_ord[i]  = fu_order[i*OW +: OW];
        end
    end
    #1;
    for (int i = 0; i < N; i++) ecnt[i*16 +: 16] = m_cnt[i][15:0];
    check("cdb_valid", 64'(cdb_valid), 64'(m_cv));
    check("cdb_rob_idx", 64'(cdb_rob_idx), 64'(m_crob));
    check("cdb_rd_addr", 64'(cdb_rd_addr), 64'(m_crd));
    check("cdb_data", 64'(cdb_data), 64'(m_cdata));
    check("cdb_fu_id", 64'(cdb_fu_id), 64'(m_cid));
    check("grant_cnt", grant_cnt, ecnt);
  endtask

  task automatic set_fu(input int i, input logic v, input logic [4:0] rob, input logic [4:0] rd,
                        input logic [31:0] d, input logic [63:0] o);
    fu_valid[i]            = v;
    fu_rob_idx[i*RW +: RW] = rob;
    fu_rd_addr[i*5 +: 5]   = rd;
    fu_data[i*DW +: DW]    = d;
    fu_order[i*OW +: OW]   = o;
  endtask

  initial begin
    logic [63:0] saved_cnt;
    logic [63:0] tag;
    logic [63:0] ro;
    for (int i = 0; i < N; i++) begin m_hv[i] = 0; m_cnt[i] = 0; end
    rst = 1; flush = 0; fu_valid = '0;
    fu_rob_idx = '0; fu_rd_addr = '0; fu_data = '0; fu_order = '0;
    cycle(); cycle();
    check("reset_cdb_valid", 64'(cdb_valid), 64'd0);
    check("reset_grant_cnt", grant_cnt, 64'd0);
    rst = 0;
    cycle();

    // Single request: visible two edges after the handshake, then gone.
    set_fu(0, 1, 5'd3, 5'd5, 32'hDEADBEEF, 64'd10);
    cycle();
    fu_valid = '0;
    cycle();
    check("single_valid", 64'(cdb_valid), 64'd1);
    check("single_rob", 64'(cdb_rob_idx), 64'd3);
    check("single_rd", 64'(cdb_rd_addr), 64'd5);
    check("single_data", 64'(cdb_data), 64'hDEADBEEF);
    check("single_fu", 64'(cdb_fu_id), 64'd0);
    cycle();
    check("single_drop", 64'(cdb_valid), 64'd0);

    // Contention: FU3 (older tag) wins; FU1 keeps offering a new result.
    set_fu(1, 1, 5'd11, 5'd1, 32'h1111, 64'd7);
    set_fu(3, 1, 5'd13, 5'd3, 32'h3333, 64'd4);
    cycle();
    fu_valid = 4'b0010;
    set_fu(1, 1, 5'd12, 5'd2, 32'h1112, 64'd20);
    cycle();
    check("contend_first", 64'(cdb_fu_id), 64'd3);
    cycle();
    check("contend_second", 64'(cdb_fu_id), 64'd1);
    check("contend_second_rob", 64'(cdb_rob_idx), 64'd11);
    fu_valid = '0;
    repeat (3) cycle();

    // Tie on tag: lower FU index first.
    set_fu(0, 1, 5'd20, 5'd0, 32'hA0, 64'd9);
    set_fu(2, 1, 5'd22, 5'd2, 32'hA2, 64'd9);
    cycle();
    fu_valid = '0;
    cycle();
    check("tie_first", 64'(cdb_fu_id), 64'd0);
    cycle();
    check("tie_second", 64'(cdb_fu_id), 64'd2);
    cycle();

    // Back-to-back single FU: one broadcast per cycle.
    set_fu(0, 1, 5'd1, 5'd7, 32'hB1, 64'd2);
    cycle();
    set_fu(0, 1, 5'd2, 5'd7, 32'hB2, 64'd3);
    cycle();
    check("b2b_1", 64'(cdb_rob_idx), 64'd1);
    set_fu(0, 1, 5'd3, 5'd7, 32'hB3, 64'd4);
    cycle();
    check("b2b_2", 64'(cdb_rob_idx), 64'd2);
    fu_valid = '0;
    cycle();
    check("b2b_3", 64'(cdb_rob_idx), 64'd3);
    check("b2b_3_valid", 64'(cdb_valid), 64'd1);
    cycle();

    // All FUs saturated with globally increasing tags: 10 grants each over 40 cycles.
    rst = 1; cycle(); rst = 0;
    tag = 0;
    for (int i = 0; i < N; i++) begin set_fu(i, 1, 5'(i), 5'(i), 32'(i), tag); tag++; end
    for (int c = 0; c < 41; c++) begin
      cycle();
      for (int i = 0; i < N; i++)
        if (exp_rdy[i]) begin set_fu(i, 1, 5'(tag), 5'(i), 32'(tag), tag); tag++; end
    end
    check("sat_counts", grant_cnt, {4{16'd10}});
    fu_valid = '0;
    repeat (5) cycle();

    // Flush with two held entries: nothing emerges, counts untouched.
    set_fu(1, 1, 5'd5, 5'd5, 32'hF1, 64'd5);
    set_fu(2, 1, 5'd6, 5'd6, 32'hF2, 64'd6);
    cycle();
    fu_valid = '0; flush = 1;
    saved_cnt = grant_cnt;
    cycle();
    check("flush_valid", 64'(cdb_valid), 64'd0);
    check("flush_cnt", grant_cnt, saved_cnt);
    flush = 0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("flush_gone", 64'(cdb_valid), 64'd0);
    end

    // Reset while FU2 holds a result.
    set_fu(2, 1, 5'd9, 5'd9, 32'hC2, 64'd50);
    cycle();
    fu_valid = '0; rst = 1;
    cycle();
    check("rst_valid", 64'(cdb_valid), 64'd0);
    check("rst_cnt", grant_cnt, 64'd0);
    check("rst_data", 64'(cdb_data), 64'd0);
    rst = 0;
    #1;
    check("rst_ready", 64'(fu_ready), 64'hF);
    cycle();

    // Random traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) ro = {$urandom, $urandom};
        else ro = 64'($urandom_range(0, 15));
        set_fu(i, 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), $urandom, ro);
      end
      flush = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 0; flush = 0; fu_valid = '0;
    repeat (4) cycle();

    // FU0 alone long enough to saturate its counter.
    tag = 100;
    for (int c = 0; c < 65600; c++) begin
      set_fu(0, 1, 5'(c), 5'd1, 32'(c), tag);
      tag++;
      cycle();
    end
    check("cnt_saturated", 64'(grant_cnt[15:0]), 64'hFFFF);
    fu_valid = '0;
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
